// File: rtl/pc_sequencer.sv
// Program counter and sequencing stage: next-PC selection, In/halt stalls, commit strobe, retire counter.
// Optional single-step mode is compiled in with `define PC_SINGLE_STEP_EN.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cu_Jump,
    input  logic                  cu_Branch,
    input  logic                  alu_zero,
    input  logic                  cu_hlt,
    input  logic                  cu_reset,
    input  logic                  cu_inSignal,
    input  logic [25:0]           jump_target,
    input  logic [15:0]           branch_offset,
    input  logic                  in_confirm,
    input  logic                  resume,
`ifdef PC_SINGLE_STEP_EN
    input  logic                  step_mode,
    input  logic                  step,
`endif
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  commit,
    output logic                  wait_in,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  instr_retired
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_IN,
        ST_HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    wait_in_q, wait_in_d;
    logic                    halted_q, halted_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    commit_d;

    logic                    conf_s1_q, conf_s2_q, conf_dly_q;
    logic                    res_s1_q, res_s2_q, res_dly_q;
    logic                    confirm_pulse, resume_pulse, run_go;

    logic [ADDR_WIDTH-1:0]   pc_inc, pc_branch, offset_ext;
    logic                    unused_jump_bits;

    assign unused_jump_bits = ^jump_target[25:ADDR_WIDTH];

    // Offset is sign-extended (or truncated) to the PC width so branch math wraps naturally.
    assign offset_ext = ADDR_WIDTH'($signed(branch_offset));
    assign pc_inc     = pc_q + ADDR_WIDTH'(1);
    assign pc_branch  = pc_inc + offset_ext;

    assign confirm_pulse = conf_s2_q & ~conf_dly_q;
    assign resume_pulse  = res_s2_q & ~res_dly_q;

`ifdef PC_SINGLE_STEP_EN
    logic step_s1_q, step_s2_q, step_dly_q;
    logic step_pulse;

    assign step_pulse = step_s2_q & ~step_dly_q;
    assign run_go     = ~step_mode | step_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            step_dly_q <= 1'b0;
        end else begin
            step_s1_q  <= step;
            step_s2_q  <= step_s1_q;
            step_dly_q <= step_s2_q;
        end
    end
`else
    assign run_go = 1'b1;
`endif

    // The if/else chain keeps X on lower-priority decoder outputs from reaching pc.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        commit_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (run_go) begin
                    if (cu_reset) begin
                        pc_d = RESET_VECTOR;
                    end else if (cu_hlt) begin
                        state_d = ST_HALT;
                    end else if (cu_inSignal) begin
                        state_d = ST_WAIT_IN;
                    end else begin
                        commit_d = 1'b1;
                        if (cu_Jump) begin
                            pc_d = jump_target[ADDR_WIDTH-1:0];
                        end else if (cu_Branch && alu_zero) begin
                            pc_d = pc_branch;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
            end
            ST_WAIT_IN: begin
                if (confirm_pulse) begin
                    commit_d = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume_pulse) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        wait_in_d = (state_d == ST_WAIT_IN);
        halted_d  = (state_d == ST_HALT);
        cnt_d     = cnt_q + CNT_WIDTH'(commit_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VECTOR;
            wait_in_q  <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
            conf_s1_q  <= 1'b0;
            conf_s2_q  <= 1'b0;
            conf_dly_q <= 1'b0;
            res_s1_q   <= 1'b0;
            res_s2_q   <= 1'b0;
            res_dly_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_in_q  <= wait_in_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
            conf_s1_q  <= in_confirm;
            conf_s2_q  <= conf_s1_q;
            conf_dly_q <= conf_s2_q;
            res_s1_q   <= resume;
            res_s2_q   <= res_s1_q;
            res_dly_q  <= res_s2_q;
        end
    end

    assign pc            = pc_q;
    assign commit        = commit_d & reset_n;
    assign wait_in       = wait_in_q;
    assign halted        = halted_q;
    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; the step-mode section is built only with PC_SINGLE_STEP_EN.
module tb_pc_sequencer;

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_RST  = 6'b100000;
    localparam logic [5:0] F_HLT  = 6'b010000;
    localparam logic [5:0] F_IN   = 6'b001000;
    localparam logic [5:0] F_JMP  = 6'b000100;
    localparam logic [5:0] F_BR   = 6'b000010;
    localparam logic [5:0] F_Z    = 6'b000001;

    typedef struct {
        logic [9:0]  pc;
        logic        commit;
        logic        waitIn;
        logic        halted;
        logic [15:0] cnt;
    } expect_t;

    logic        clk;
    logic        reset_n;
    logic        cu_Jump, cu_Branch, alu_zero, cu_hlt, cu_reset, cu_inSignal;
    logic [25:0] jump_target;
    logic [15:0] branch_offset;
    logic        in_confirm, resume;
    logic        step_mode, step;
    logic [9:0]  pc;
    logic        commit, wait_in, halted;
    logic [15:0] instr_retired;

    expect_t     expQ[$];
    int          testsRun    = 0;
    int          testsFailed = 0;

    pc_sequencer #(
        .ADDR_WIDTH  (10),
        .RESET_VECTOR(10'd0),
        .CNT_WIDTH   (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cu_Jump      (cu_Jump),
        .cu_Branch    (cu_Branch),
        .alu_zero     (alu_zero),
        .cu_hlt       (cu_hlt),
        .cu_reset     (cu_reset),
        .cu_inSignal  (cu_inSignal),
        .jump_target  (jump_target),
        .branch_offset(branch_offset),
        .in_confirm   (in_confirm),
        .resume       (resume),
`ifdef PC_SINGLE_STEP_EN
        .step_mode    (step_mode),
        .step         (step),
`endif
        .pc           (pc),
        .commit       (commit),
        .wait_in      (wait_in),
        .halted       (halted),
        .instr_retired(instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives the decoder-side inputs and queues what the DUT must show during this cycle.
    task automatic applyStimulus(input logic [5:0] flags, input logic [25:0] jt, input logic [15:0] off,
                                 input logic [9:0] ePc, input logic eCommit, input logic eWait,
                                 input logic eHalt, input logic [15:0] eCnt);
        expect_t e;
        {cu_reset, cu_hlt, cu_inSignal, cu_Jump, cu_Branch, alu_zero} = flags;
        jump_target   = jt;
        branch_offset = off;
        e.pc     = ePc;
        e.commit = eCommit;
        e.waitIn = eWait;
        e.halted = eHalt;
        e.cnt    = eCnt;
        expQ.push_back(e);
    endtask

    task automatic checkField(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        expect_t e;
        #1;
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e = expQ.pop_front();
            checkField("pc", 16'(pc), 16'(e.pc));
            checkField("commit", 16'(commit), 16'(e.commit));
            checkField("wait_in", 16'(wait_in), 16'(e.waitIn));
            checkField("halted", 16'(halted), 16'(e.halted));
            checkField("instr_retired", instr_retired, e.cnt);
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic [5:0] flags, input logic [25:0] jt, input logic [15:0] off,
                       input logic [9:0] ePc, input logic eCommit, input logic eWait,
                       input logic eHalt, input logic [15:0] eCnt);
        applyStimulus(flags, jt, off, ePc, eCommit, eWait, eHalt, eCnt);
        checkOutput();
    endtask

    initial begin
        reset_n    = 1'b0;
        in_confirm = 1'b0;
        resume     = 1'b0;
        step_mode  = 1'b0;
        step       = 1'b0;
        cyc(F_NONE, 26'd0, 16'd0, 10'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset_n = 1'b1;

        // Sequential fetch from the reset vector.
        for (int i = 0; i < 8; i++) begin
            cyc(F_NONE, 26'd0, 16'd0, 10'(i), 1'b1, 1'b0, 1'b0, 16'(i));
            if (i == 6) break;
        end
        cyc(F_BR | F_Z, 26'd0, 16'hFFFD, 10'd7, 1'b1, 1'b0, 1'b0, 16'd7);
        cyc(F_BR, 26'd0, 16'h0010, 10'd5, 1'b1, 1'b0, 1'b0, 16'd8);
        cyc(F_JMP, 26'h2A003FF, 16'd0, 10'd6, 1'b1, 1'b0, 1'b0, 16'd9);
        cyc(F_NONE, 26'd0, 16'd0, 10'd1023, 1'b1, 1'b0, 1'b0, 16'd10);
        cyc(F_JMP, 26'd4, 16'd0, 10'd0, 1'b1, 1'b0, 1'b0, 16'd11);

        // In instruction, soft reset ignored while waiting, then confirm together with resume.
        cyc(F_IN, 26'd0, 16'd0, 10'd4, 1'b0, 1'b0, 1'b0, 16'd12);
        cyc(F_NONE, 26'd0, 16'd0, 10'd4, 1'b0, 1'b1, 1'b0, 16'd12);
        cyc(F_RST, 26'd0, 16'd0, 10'd4, 1'b0, 1'b1, 1'b0, 16'd12);
        in_confirm = 1'b1;
        resume     = 1'b1;
        cyc(F_NONE, 26'd0, 16'd0, 10'd4, 1'b0, 1'b1, 1'b0, 16'd12);
        cyc(F_NONE, 26'd0, 16'd0, 10'd4, 1'b0, 1'b1, 1'b0, 16'd12);
        cyc(F_NONE, 26'd0, 16'd0, 10'd4, 1'b1, 1'b1, 1'b0, 16'd12);
        in_confirm = 1'b0;
        resume     = 1'b0;
        cyc(F_NONE, 26'd0, 16'd0, 10'd5, 1'b1, 1'b0, 1'b0, 16'd13);
        cyc(F_NONE, 26'd0, 16'd0, 10'd6, 1'b1, 1'b0, 1'b0, 16'd14);
        cyc(F_NONE, 26'd0, 16'd0, 10'd7, 1'b1, 1'b0, 1'b0, 16'd15);
        cyc(F_NONE, 26'd0, 16'd0, 10'd8, 1'b1, 1'b0, 1'b0, 16'd16);

        // Halt with an undefined jump flag; confirm is ignored, resume leaves without retiring.
        cyc(6'b010x00, 26'd0, 16'd0, 10'd9, 1'b0, 1'b0, 1'b0, 16'd17);
        in_confirm = 1'b1;
        cyc(F_NONE, 26'd0, 16'd0, 10'd9, 1'b0, 1'b0, 1'b1, 16'd17);
        in_confirm = 1'b0;
        for (int i = 0; i < 3; i++) cyc(F_NONE, 26'd0, 16'd0, 10'd9, 1'b0, 1'b0, 1'b1, 16'd17);
        resume = 1'b1;
        for (int i = 0; i < 3; i++) cyc(F_NONE, 26'd0, 16'd0, 10'd9, 1'b0, 1'b0, 1'b1, 16'd17);
        cyc(F_NONE, 26'd0, 16'd0, 10'd10, 1'b1, 1'b0, 1'b0, 16'd17);
        resume = 1'b0;
        cyc(F_JMP, 26'd20, 16'd0, 10'd11, 1'b1, 1'b0, 1'b0, 16'd18);

        // Soft reset outranks jump; then a hard reset in WAIT_IN acts without a clock edge.
        cyc(F_RST | F_JMP, 26'h3FF, 16'd0, 10'd20, 1'b0, 1'b0, 1'b0, 16'd19);
        cyc(F_NONE, 26'd0, 16'd0, 10'd0, 1'b1, 1'b0, 1'b0, 16'd19);
        cyc(F_IN, 26'd0, 16'd0, 10'd1, 1'b0, 1'b0, 1'b0, 16'd20);
        applyStimulus(F_NONE, 26'd0, 16'd0, 10'd1, 1'b0, 1'b1, 1'b0, 16'd20);
        checkOutput();
        #2 reset_n = 1'b0;
        applyStimulus(F_NONE, 26'd0, 16'd0, 10'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        checkOutput();

        // A held confirm raised outside WAIT_IN yields no later pulse.
        reset_n    = 1'b1;
        in_confirm = 1'b1;
        cyc(F_NONE, 26'd0, 16'd0, 10'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(F_NONE, 26'd0, 16'd0, 10'd1, 1'b1, 1'b0, 1'b0, 16'd1);
        cyc(F_NONE, 26'd0, 16'd0, 10'd2, 1'b1, 1'b0, 1'b0, 16'd2);
        cyc(F_IN, 26'd0, 16'd0, 10'd3, 1'b0, 1'b0, 1'b0, 16'd3);
        for (int i = 0; i < 3; i++) cyc(F_NONE, 26'd0, 16'd0, 10'd3, 1'b0, 1'b1, 1'b0, 16'd3);
        in_confirm = 1'b0;
        cyc(F_NONE, 26'd0, 16'd0, 10'd3, 1'b0, 1'b1, 1'b0, 16'd3);
        in_confirm = 1'b1;
        cyc(F_NONE, 26'd0, 16'd0, 10'd3, 1'b0, 1'b1, 1'b0, 16'd3);
        cyc(F_NONE, 26'd0, 16'd0, 10'd3, 1'b0, 1'b1, 1'b0, 16'd3);
        cyc(F_NONE, 26'd0, 16'd0, 10'd3, 1'b1, 1'b1, 1'b0, 16'd3);
        in_confirm = 1'b0;
        cyc(F_NONE, 26'd0, 16'd0, 10'd4, 1'b1, 1'b0, 1'b0, 16'd4);

`ifdef PC_SINGLE_STEP_EN
        step_mode = 1'b1;
        for (int i = 0; i < 10; i++) cyc(F_NONE, 26'd0, 16'd0, 10'd5, 1'b0, 1'b0, 1'b0, 16'd5);
        step = 1'b1;
        cyc(F_NONE, 26'd0, 16'd0, 10'd5, 1'b0, 1'b0, 1'b0, 16'd5);
        cyc(F_NONE, 26'd0, 16'd0, 10'd5, 1'b0, 1'b0, 1'b0, 16'd5);
        cyc(F_NONE, 26'd0, 16'd0, 10'd5, 1'b1, 1'b0, 1'b0, 16'd5);
        cyc(F_NONE, 26'd0, 16'd0, 10'd6, 1'b0, 1'b0, 1'b0, 16'd6);
        cyc(F_NONE, 26'd0, 16'd0, 10'd6, 1'b0, 1'b0, 1'b0, 16'd6);
        step = 1'b0;
        for (int i = 0; i < 3; i++) cyc(F_NONE, 26'd0, 16'd0, 10'd6, 1'b0, 1'b0, 1'b0, 16'd6);
        step = 1'b1;
        cyc(F_NONE, 26'd0, 16'd0, 10'd6, 1'b0, 1'b0, 1'b0, 16'd6);
        cyc(F_NONE, 26'd0, 16'd0, 10'd6, 1'b0, 1'b0, 1'b0, 16'd6);
        cyc(F_NONE, 26'd0, 16'd0, 10'd6, 1'b1, 1'b0, 1'b0, 16'd6);
        step = 1'b0;
        cyc(F_NONE, 26'd0, 16'd0, 10'd7, 1'b0, 1'b0, 1'b0, 16'd7);
        step_mode = 1'b0;
        cyc(F_NONE, 26'd0, 16'd0, 10'd7, 1'b1, 1'b0, 1'b0, 16'd7);
`else
        cyc(F_NONE, 26'd0, 16'd0, 10'd5, 1'b1, 1'b0, 1'b0, 16'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
